hazard_ctrl: RTL

//   Pipeline sequencer for the 5-stage core: drives enable/flush of pc, if_id, id_ex, ex_mem, mem_wb.

---
 rtl/hazard_ctrl.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencer for the 5-stage core.
// It drives the enable and flush signals of pc, if_id, id_ex, ex_mem and mem_wb.
// It resolves load-use hazards, branch redirects, imem/dmem waits and multi-cycle EX ops.
// After reset it fills the pipe with bubbles for INIT_CYCLES cycles.
// It keeps stall and flush performance counters and a sticky dmem-wait watchdog.
//
// Ports:
//   i_clk, i_rst_n                 clock (rising edge), async active-low reset
//   i_id_rs1/2, i_id_use_rs1/2     source registers of the instruction in ID
//   i_ex_rd, i_ex_mem_read         destination register of the EX instruction, and a load flag
//   i_ex_redirect                  taken branch/jump resolved in EX
//   i_ex_mc_start, i_ex_mc_done    multi-cycle EX op start / result valid
//   i_imem_valid, i_dmem_busy      fetch data valid / data memory not ready
//   o_*_en, o_*_flush              stage load enables and bubble inserts (combinational)
//   o_stall_cnt, o_flush_cnt       stall-cycle and redirect-flush counters
//   o_wdog_err                     sticky dmem-busy timeout
module hazard_ctrl #(
    parameter int unsigned INIT_CYCLES = 4,
    parameter int unsigned WDOG_MAX    = 255,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [4:0]       i_id_rs1,
    input  logic [4:0]       i_id_rs2,
    input  logic             i_id_use_rs1,
    input  logic             i_id_use_rs2,
    input  logic [4:0]       i_ex_rd,
    input  logic             i_ex_mem_read,
    input  logic             i_ex_redirect,
    input  logic             i_ex_mc_start,
    input  logic             i_ex_mc_done,
    input  logic             i_imem_valid,
    input  logic             i_dmem_busy,
    output logic             o_pc_en,
    output logic             o_if_id_en,
    output logic             o_if_id_flush,
    output logic             o_id_ex_en,
    output logic             o_id_ex_flush,
    output logic             o_ex_mem_en,
    output logic             o_ex_mem_flush,
    output logic             o_mem_wb_en,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt,
    output logic             o_wdog_err
);

    localparam int unsigned INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam int unsigned WD_W   = $clog2(WDOG_MAX + 1);

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_RUN     = 2'd1,
        ST_MC_WAIT = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [INIT_W-1:0] init_cnt;
    logic [WD_W-1:0]   wd_cnt;
    logic [WD_W-1:0]   wd_inc;
    logic              load_use_c;
    logic              redirect_evt_c;

    // The load in EX writes a register that the instruction in ID reads; x0 never hazards.
    assign load_use_c = i_ex_mem_read && (i_ex_rd != 5'd0) &&
                        ((i_id_use_rs1 && (i_id_rs1 == i_ex_rd)) ||
                         (i_id_use_rs2 && (i_id_rs2 == i_ex_rd)));

    // The watchdog increment saturates at WDOG_MAX.
    assign wd_inc = (wd_cnt == WD_W'(WDOG_MAX)) ? wd_cnt : wd_cnt + WD_W'(1);

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and stage controls
    always_comb begin
        state_nxt      = state;
        redirect_evt_c = 1'b0;
        o_pc_en        = 1'b1;
        o_if_id_en     = 1'b1;
        o_if_id_flush  = 1'b0;
        o_id_ex_en     = 1'b1;
        o_id_ex_flush  = 1'b0;
        o_ex_mem_en    = 1'b1;
        o_ex_mem_flush = 1'b0;
        o_mem_wb_en    = 1'b1;

        unique case (state)
            ST_INIT: begin
                o_pc_en        = 1'b0;
                o_if_id_flush  = 1'b1;
                o_id_ex_flush  = 1'b1;
                o_ex_mem_flush = 1'b1;
                if (init_cnt == INIT_W'(INIT_CYCLES - 1)) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (i_dmem_busy) begin
                    o_pc_en     = 1'b0;
                    o_if_id_en  = 1'b0;
                    o_id_ex_en  = 1'b0;
                    o_ex_mem_en = 1'b0;
                    o_mem_wb_en = 1'b0;
                end else if (i_ex_redirect) begin
                    o_if_id_flush  = 1'b1;
                    o_id_ex_flush  = 1'b1;
                    redirect_evt_c = 1'b1;
                end else if (i_ex_mc_start && !i_ex_mc_done) begin
                    // If start and done arrive in the same cycle, the op is already complete.
                    o_pc_en        = 1'b0;
                    o_if_id_en     = 1'b0;
                    o_id_ex_en     = 1'b0;
                    o_ex_mem_flush = 1'b1;
                    state_nxt      = ST_MC_WAIT;
                end else if (load_use_c) begin
                    o_pc_en       = 1'b0;
                    o_if_id_en    = 1'b0;
                    o_id_ex_flush = 1'b1;
                end else if (!i_imem_valid) begin
                    o_pc_en       = 1'b0;
                    o_if_id_flush = 1'b1;
                end
            end
            ST_MC_WAIT: begin
                if (i_dmem_busy) begin
                    o_pc_en     = 1'b0;
                    o_if_id_en  = 1'b0;
                    o_id_ex_en  = 1'b0;
                    o_ex_mem_en = 1'b0;
                    o_mem_wb_en = 1'b0;
                end else if (i_ex_mc_done) begin
                    state_nxt = ST_RUN;
                end else begin
                    o_pc_en        = 1'b0;
                    o_if_id_en     = 1'b0;
                    o_id_ex_en     = 1'b0;
                    o_ex_mem_flush = 1'b1;
                end
            end
            default: begin
                o_pc_en   = 1'b0;
                state_nxt = ST_INIT;
            end
        endcase

        // Asserting reset forces the reset controls in the same cycle, independent of state.
        if (!i_rst_n) begin
            o_pc_en        = 1'b0;
            o_if_id_en     = 1'b0;
            o_id_ex_en     = 1'b0;
            o_ex_mem_en    = 1'b0;
            o_mem_wb_en    = 1'b0;
            o_if_id_flush  = 1'b1;
            o_id_ex_flush  = 1'b1;
            o_ex_mem_flush = 1'b1;
            redirect_evt_c = 1'b0;
        end
    end

    // Post-reset bubble-fill counter
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            init_cnt <= '0;
        end else if (state == ST_INIT) begin
            init_cnt <= init_cnt + INIT_W'(1);
        end else begin
            init_cnt <= '0;
        end
    end

    // dmem-busy watchdog; the error flag is sticky until reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wd_cnt     <= '0;
            o_wdog_err <= 1'b0;
        end else if ((state != ST_INIT) && i_dmem_busy) begin
            wd_cnt <= wd_inc;
            if (wd_inc == WD_W'(WDOG_MAX)) begin
                o_wdog_err <= 1'b1;
            end
        end else begin
            wd_cnt <= '0;
        end
    end

    // Performance counters; they wrap and are frozen in INIT
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_stall_cnt <= '0;
            o_flush_cnt <= '0;
        end else if (state != ST_INIT) begin
            if (!o_pc_en) begin
                o_stall_cnt <= o_stall_cnt + CNT_W'(1);
            end
            if (redirect_evt_c) begin
                o_flush_cnt <= o_flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule
